// File: rtl/bt_stream_pkg.sv
// Shared types and constants for the Bluetooth sample-stream framer and its UART.
package bt_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SELECT,
        ST_SEND,
        ST_WAIT
    } fsm_state_e;

    localparam logic [7:0] DEFAULT_HEADER     = 8'hA5;
    localparam logic       UART_START_BIT     = 1'b0;
    localparam logic       UART_STOP_BIT      = 1'b1;
    localparam int         UART_BITS_PER_BYTE = 10;

    function automatic int bytes_per_sample(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART transmitter, LSB first; a start request while a byte is on the line is ignored.
module uart_tx_byte
    import bt_stream_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       tx_start,
    input  logic [7:0] tx_byte,
    output logic       txd,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] clk_cnt_q;
    logic [3:0]       bit_cnt_q;
    logic [8:0]       shift_q;
    logic             txd_q;
    logic             busy_q;
    logic             done_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '1;
            txd_q     <= UART_STOP_BIT;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!busy_q) begin
                if (tx_start) begin
                    busy_q    <= 1'b1;
                    txd_q     <= UART_START_BIT;
                    shift_q   <= {UART_STOP_BIT, tx_byte};
                    clk_cnt_q <= '0;
                    bit_cnt_q <= '0;
                end
            end else if (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                clk_cnt_q <= '0;
                if (bit_cnt_q == 4'(UART_BITS_PER_BYTE - 1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    txd_q  <= UART_STOP_BIT;
                end else begin
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                    txd_q     <= shift_q[0];
                    shift_q   <= {UART_STOP_BIT, shift_q[8:1]};
                end
            end else begin
                clk_cnt_q <= clk_cnt_q + 1'b1;
            end
        end
    end

    assign txd     = txd_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: rtl/bt_stream_framer.sv
// Round-robin multi-channel sample capture, framed as header/channel/payload bytes over UART.
module bt_stream_framer
    import bt_stream_pkg::*;
#(
    parameter int         NUM_CHANNELS = 4,
    parameter int         DATA_WIDTH   = 16,
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] HEADER_BYTE  = DEFAULT_HEADER
) (
    input  logic                               clock,
    input  logic                               resetn,
    input  logic                               bt_state,
    input  logic                               stream_enable,
    input  logic [NUM_CHANNELS-1:0]            channel_mask,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] ch_data,
    input  logic [NUM_CHANNELS-1:0]            ch_valid,
    output logic                               fpga_txd,
    output logic                               busy,
    output logic [NUM_CHANNELS-1:0]            pending,
    output logic [15:0]                        overrun_count,
    output logic [15:0]                        frames_sent
);

    localparam int CH_W    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int BYTES   = 2 + bytes_per_sample(DATA_WIDTH);
    localparam int FRAME_W = BYTES * 8;
    localparam int IDX_W   = $clog2(BYTES);

    fsm_state_e                                state_q;
    logic [CH_W-1:0]                           ptr_q;
    logic [FRAME_W-1:0]                        frame_q;
    logic [IDX_W-1:0]                          idx_q;
    logic                                      busy_q, abort_q;
    logic [15:0]                               frames_q;
    logic [15:0]                               overrun_q, overrun_d;
    logic [NUM_CHANNELS-1:0]                   pending_q, pending_d;
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]   hold_q, hold_d;
    logic [NUM_CHANNELS-1:0]                   take;
    logic [CH_W-1:0]                           sel_idx;
    logic [16:0]                               ovf_sum;
    logic                                      link_ok, tx_start, tx_done, uart_busy;

    // First requester strictly after ptr, wrapping; ptr itself is considered last.
    function automatic logic [CH_W-1:0] rr_pick(input logic [NUM_CHANNELS-1:0] req,
                                                 input logic [CH_W-1:0] ptr);
        logic [CH_W-1:0] c;
        rr_pick = ptr;
        for (int k = NUM_CHANNELS; k >= 1; k--) begin
            c = CH_W'((int'(ptr) + k) % NUM_CHANNELS);
            if (req[c]) rr_pick = c;
        end
    endfunction

    assign link_ok = bt_state & stream_enable;
    assign sel_idx = rr_pick(pending_q, ptr_q);

    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        take = '0;
        if (state_q == ST_SELECT && |pending_q) take[sel_idx] = 1'b1;
    end

    always_comb begin
        pending_d = pending_q;
        hold_d    = hold_q;
        ovf_sum   = {1'b0, overrun_q};
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (!channel_mask[i]) begin
                pending_d[i] = 1'b0;
            end else if (ch_valid[i]) begin
                hold_d[i]    = ch_data[i*DATA_WIDTH +: DATA_WIDTH];
                pending_d[i] = 1'b1;
                if (pending_q[i] && !take[i]) ovf_sum = ovf_sum + 17'd1;
            end else if (take[i]) begin
                pending_d[i] = 1'b0;
            end
        end
        overrun_d = ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            ptr_q     <= CH_W'(NUM_CHANNELS - 1);
            frame_q   <= '0;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            abort_q   <= 1'b0;
            frames_q  <= '0;
            overrun_q <= '0;
            pending_q <= '0;
            hold_q    <= '0;
        end else begin
            pending_q <= pending_d;
            hold_q    <= hold_d;
            overrun_q <= overrun_d;
            case (state_q)
                ST_IDLE: begin
                    if (link_ok && |pending_q) state_q <= ST_SELECT;
                end
                ST_SELECT: begin
                    if (|pending_q) begin
                        frame_q <= {HEADER_BYTE, 8'(sel_idx), hold_q[sel_idx]};
                        ptr_q   <= sel_idx;
                        busy_q  <= 1'b1;
                        idx_q   <= '0;
                        abort_q <= 1'b0;
                        state_q <= ST_SEND;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SEND: begin
                    if (!link_ok) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A link drop mid-byte is remembered; the byte finishes, then the frame is dropped.
                    if (tx_done) begin
                        if (abort_q || !link_ok) begin
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else if (idx_q == IDX_W'(BYTES - 1)) begin
                            frames_q <= frames_q + 16'd1;
                            busy_q   <= 1'b0;
                            state_q  <= ST_IDLE;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            frame_q <= {frame_q[FRAME_W-9:0], 8'h00};
                            state_q <= ST_SEND;
                        end
                    end else if (!link_ok) begin
                        abort_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign tx_start = (state_q == ST_SEND) && link_ok && !uart_busy;

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clock   (clock),
        .resetn  (resetn),
        .tx_start(tx_start),
        .tx_byte (frame_q[FRAME_W-1 -: 8]),
        .txd     (fpga_txd),
        .tx_busy (uart_busy),
        .tx_done (tx_done)
    );

    assign busy          = busy_q;
    assign pending       = pending_q;
    assign overrun_count = overrun_q;
    assign frames_sent   = frames_q;

endmodule

// File: tb/tb_bt_stream_framer.sv
// Directed bench: a line-level UART receiver checks every byte against an expected-frame queue.
module tb_bt_stream_framer;

    localparam int C      = 4;
    localparam int NCH    = 4;
    localparam int DW     = 16;
    localparam int BYTE_T = 10 * C;

    logic           clock = 1'b0;
    logic           resetn;
    logic           bt_state, stream_enable;
    logic [NCH-1:0] channel_mask, ch_valid, pending;
    logic [NCH*DW-1:0] ch_data;
    logic           fpga_txd, busy;
    logic [15:0]    overrun_count, frames_sent;

    bt_stream_framer #(
        .NUM_CHANNELS(NCH),
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(C),
        .HEADER_BYTE (8'hA5)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .bt_state     (bt_state),
        .stream_enable(stream_enable),
        .channel_mask (channel_mask),
        .ch_data      (ch_data),
        .ch_valid     (ch_valid),
        .fpga_txd     (fpga_txd),
        .busy         (busy),
        .pending      (pending),
        .overrun_count(overrun_count),
        .frames_sent  (frames_sent)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] b;
        bit         last;
    } exp_t;

    exp_t exp_q[$];
    int   start_cyc_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   exp_frames = 0;
    int   inc_at = -1;
    int   rx_starts = 0;
    bit   rx_active = 0;
    int   rx_n = 0;
    logic samp [0:BYTE_T-1];

    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model of the line: decode each 8N1 byte, check bit timing, compare with the expected queue.
    always @(negedge clock) begin
        if (!resetn) begin
            rx_active  = 0;
            exp_frames = 0;
            inc_at     = -1;
        end else begin
            if (inc_at >= 0 && cyc >= inc_at) begin
                exp_frames++;
                inc_at = -1;
            end
            check("frames_sent", 32'(frames_sent), 32'(exp_frames));
            if (rx_active) begin
                check("busy_during_byte", 32'(busy), 32'd1);
                samp[rx_n] = fpga_txd;
                rx_n++;
                if (rx_n == BYTE_T) begin
                    logic [7:0] got;
                    bit stable;
                    rx_active = 0;
                    stable = 1;
                    for (int b = 0; b < 10; b++)
                        for (int k = 1; k < C; k++)
                            if (samp[b*C+k] !== samp[b*C]) stable = 0;
                    check("bit_timing", 32'(stable), 32'd1);
                    check("stop_bit", 32'(samp[9*C]), 32'd1);
                    for (int b = 0; b < 8; b++) got[b] = samp[(b+1)*C];
                    if (exp_q.size() == 0) begin
                        check("unexpected_byte", 32'(got), 32'h100);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("tx_byte", 32'(got), 32'(e.b));
                        if (e.last) inc_at = cyc + 2;
                    end
                end
            end else if (fpga_txd === 1'b0) begin
                rx_active = 1;
                samp[0]   = 1'b0;
                rx_n      = 1;
                rx_starts++;
                start_cyc_q.push_back(cyc);
            end
        end
    end

    task automatic push_frame(input int ch, input logic [15:0] v, input int nbytes);
        logic [7:0] bytes [4];
        bytes[0] = 8'hA5;
        bytes[1] = 8'(ch);
        bytes[2] = v[15:8];
        bytes[3] = v[7:0];
        for (int i = 0; i < nbytes; i++) exp_q.push_back('{bytes[i], (nbytes == 4) && (i == 3)});
    endtask

    // Caller is at posedge+1; valid is held for exactly one cycle.
    task automatic strobe(input logic [NCH-1:0] chans, input logic [NCH*DW-1:0] data);
        ch_data  = data;
        ch_valid = chans;
        @(posedge clock); #1;
        ch_valid = '0;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || rx_active || inc_at >= 0 || busy !== 1'b0) && n < budget) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= budget) check({name, "_timeout"}, 32'(n), 32'(budget - 1));
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic wait_starts(input int target, input int budget);
        int n = 0;
        while (rx_starts < target && n < budget) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= budget) check("start_wait_timeout", 32'(rx_starts), 32'(target));
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        exp_q.delete();
        @(posedge clock); #1;
        resetn = 1'b1;
    endtask

    initial begin
        int base, lat;
        resetn        = 1'b0;
        bt_state      = 1'b1;
        stream_enable = 1'b1;
        channel_mask  = 4'b0001;
        ch_data       = '0;
        ch_valid      = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_txd", 32'(fpga_txd), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_pending", 32'(pending), 32'd0);
        check("reset_overrun", 32'(overrun_count), 32'd0);
        check("reset_frames", 32'(frames_sent), 32'd0);
        resetn = 1'b1;
        @(posedge clock); #1;

        // Single frame on channel 0: A5 00 12 34.
        exp_q.push_back('{8'hA5, 1'b0});
        exp_q.push_back('{8'h00, 1'b0});
        exp_q.push_back('{8'h12, 1'b0});
        exp_q.push_back('{8'h34, 1'b1});
        start_cyc_q.delete();
        strobe(4'b0001, 64'h0000_0000_0000_1234);
        lat = 0;
        while (fpga_txd !== 1'b0 && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
        // Strobe cycle s: capture, IDLE s+1, SELECT s+2, SEND s+3, start bit s+4.
        check("start_latency", 32'(lat), 32'd3);
        drain("frame1", 400);
        check("frame1_frames", 32'(frames_sent), 32'd1);
        check("frame1_pending", 32'(pending), 32'd0);
        check("frame1_busy", 32'(busy), 32'd0);
        check("frame1_nbytes", 32'(start_cyc_q.size()), 32'd4);
        if (start_cyc_q.size() == 4)
            for (int i = 1; i < 4; i++)
                check("byte_spacing", 32'(start_cyc_q[i] - start_cyc_q[i-1]), 32'(BYTE_T + 2));

        // Round-robin from a fresh pointer: 0,1,2,3; then ch2 alone; then {1,3} gives 3,1.
        apply_reset();
        channel_mask = 4'b1111;
        push_frame(0, 16'h1111, 4);
        push_frame(1, 16'h2222, 4);
        push_frame(2, 16'h3333, 4);
        push_frame(3, 16'h4444, 4);
        strobe(4'b1111, {16'h4444, 16'h3333, 16'h2222, 16'h1111});
        drain("rr_all", 2000);
        check("rr_all_frames", 32'(frames_sent), 32'd4);
        push_frame(2, 16'h5555, 4);
        strobe(4'b0100, {16'h0, 16'h5555, 16'h0, 16'h0});
        drain("rr_ch2", 600);
        push_frame(3, 16'h7777, 4);
        push_frame(1, 16'h6666, 4);
        strobe(4'b1010, {16'h7777, 16'h0, 16'h6666, 16'h0});
        drain("rr_31", 1000);
        check("rr_frames", 32'(frames_sent), 32'd7);
        check("rr_overrun", 32'(overrun_count), 32'd0);

        // Overrun: ch2 strobed twice while ch0 is on the line.
        base = rx_starts;
        push_frame(0, 16'h0A0B, 4);
        strobe(4'b0001, {48'h0, 16'h0A0B});
        wait_starts(base + 1, 50);
        strobe(4'b0100, {16'h0, 16'hAAAA, 32'h0});
        @(posedge clock); #1;
        strobe(4'b0100, {16'h0, 16'hBBBB, 32'h0});
        check("overrun_count", 32'(overrun_count), 32'd1);
        check("overrun_pending", 32'(pending), 32'b0100);
        push_frame(2, 16'hBBBB, 4);
        drain("overrun", 1000);
        check("overrun_frames", 32'(frames_sent), 32'd9);
        check("overrun_hold", 32'(overrun_count), 32'd1);

        // Strobe ch1 in the exact cycle SELECT takes it: old value first, new value next.
        push_frame(1, 16'h5A5A, 4);
        push_frame(1, 16'hC3C3, 4);
        strobe(4'b0010, {32'h0, 16'h5A5A, 16'h0});
        @(posedge clock); #1;
        strobe(4'b0010, {32'h0, 16'hC3C3, 16'h0});
        check("collide_pending", 32'(pending), 32'b0010);
        check("collide_overrun", 32'(overrun_count), 32'd1);
        drain("collide", 1000);
        check("collide_frames", 32'(frames_sent), 32'd11);
        check("collide_pending_after", 32'(pending), 32'd0);

        // Link loss during the first payload byte: that byte completes, frame is dropped.
        base = rx_starts;
        push_frame(0, 16'hBEEF, 3);
        strobe(4'b0001, {48'h0, 16'hBEEF});
        wait_starts(base + 3, 300);
        repeat (5) @(posedge clock);
        #1;
        bt_state = 1'b0;
        drain("linkloss", 200);
        check("linkloss_frames", 32'(frames_sent), 32'd11);
        check("linkloss_busy", 32'(busy), 32'd0);
        check("linkloss_txd", 32'(fpga_txd), 32'd1);
        check("linkloss_pending", 32'(pending), 32'd0);
        bt_state = 1'b1;
        repeat (60) @(posedge clock);
        #1;
        check("linkloss_idle_busy", 32'(busy), 32'd0);
        check("linkloss_no_resend", 32'(rx_starts), 32'(base + 3));

        // Reset mid-byte, then no transmission while the link is down.
        channel_mask = 4'b0001;
        base = rx_starts;
        push_frame(0, 16'h7777, 4);
        strobe(4'b0001, {48'h0, 16'h7777});
        wait_starts(base + 1, 50);
        repeat (10) @(posedge clock);
        #3;
        resetn = 1'b0;
        #1;
        check("rst_txd", 32'(fpga_txd), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_overrun", 32'(overrun_count), 32'd0);
        check("rst_frames", 32'(frames_sent), 32'd0);
        exp_q.delete();
        bt_state = 1'b0;
        @(posedge clock); #1;
        resetn = 1'b1;
        @(posedge clock); #1;
        base = rx_starts;
        strobe(4'b0001, {48'h0, 16'h9999});
        check("nolink_pending", 32'(pending), 32'b0001);
        repeat (100) @(posedge clock);
        #1;
        check("nolink_busy", 32'(busy), 32'd0);
        check("nolink_txd", 32'(fpga_txd), 32'd1);
        check("nolink_frames", 32'(frames_sent), 32'd0);
        check("nolink_no_bytes", 32'(rx_starts), 32'(base));
        check("nolink_pending_kept", 32'(pending), 32'b0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
